mux_rr_arbiter: RTL



---
 rtl/mux_rr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Purpose : round-robin arbiter for a shared 4:1 mux with a bounded hold time per owner.
// Latency : 1 cycle from req to registered gnt/sel; zero-bubble handover between owners.
// Backpres: an owner keeps the grant while it requests, up to MAX_HOLD cycles while others wait.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req[3:0]   : level requests, bit i drives mux input i
//   gnt[3:0]   : registered one-hot grant, zero when idle
//   sel[1:0]   : registered mux select, index of the set gnt bit (held while idle)
//   valid      : any grant active (OR of gnt)
//   hold_cnt   : cycles the current owner has held the grant, saturates at MAX_HOLD
//
// Optional build macro: MUX_ARB_ASSERT_EN compiles in protocol assertions.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic [7:0] hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [1:0] last, last_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] gnt_nxt;
    logic [7:0] hold_nxt;
    logic [3:0] own_mask;
    logic [2:0] pick_all;   // {found, index} searching every requester
    logic [2:0] pick_oth;   // {found, index} with the current owner excluded

    // Search last+1, last+2, last+3, last. The loop runs from the farthest
    // offset so the nearest matching index overwrites and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k + 1);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign own_mask = 4'b0001 << last;
    assign pick_all = rr_pick(req, last);
    assign pick_oth = rr_pick(req & ~own_mask, last);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_all[2]) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << pick_all[1:0];
                    sel_nxt   = pick_all[1:0];
                    last_nxt  = pick_all[1:0];
                    hold_nxt  = 8'd1;
                end
            end
            GRANT: begin
                // In GRANT the owner is always 'last'. Release and expiry both
                // rotate to the next other requester, so they share one path.
                if (!req[last] || hold_cnt >= MAX_HOLD_C) begin
                    if (pick_oth[2]) begin
                        gnt_nxt  = 4'b0001 << pick_oth[1:0];
                        sel_nxt  = pick_oth[1:0];
                        last_nxt = pick_oth[1:0];
                        hold_nxt = 8'd1;
                    end else if (!req[last]) begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        hold_nxt  = 8'd0;
                    end else begin
                        // Sole requester at the limit: keep it, stay saturated.
                        hold_nxt = MAX_HOLD_C;
                    end
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                hold_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            valid    <= 1'b0;
            hold_cnt <= 8'd0;
            last     <= 2'd3;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            valid    <= |gnt_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
        end
    end

`ifdef MUX_ARB_ASSERT_EN
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("%0t: gnt not onehot0", $time);
    a_valid: assert property (@(posedge clk) disable iff (!rst_n) valid == (|gnt))
        else $error("%0t: valid differs from OR of gnt", $time);
    a_sel: assert property (@(posedge clk) disable iff (!rst_n) valid |-> gnt[sel])
        else $error("%0t: sel does not match gnt", $time);
    a_hold: assert property (@(posedge clk) disable iff (!rst_n) hold_cnt <= MAX_HOLD_C)
        else $error("%0t: hold_cnt above MAX_HOLD", $time);

    for (genvar i = 0; i < 4; i++) begin : g_req_chk
        a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
            $rose(gnt[i]) |-> $past(req[i]))
            else $error("%0t: gnt[%0d] without prior req", $time, i);
        // A request that stays up must be served within the bounded window.
        a_live: assert property (@(posedge clk) disable iff (!rst_n)
            (req[i] && !gnt[i]) |-> ##[0:3*MAX_HOLD+1] (gnt[i] || !req[i]))
            else $error("%0t: req[%0d] starved", $time, i);
    end
`endif

endmodule
